// File: rtl/seq_pkg.sv
// Shared sequence codes and term-0 model state for the sequence generators
// and the receive-side identifier.
package seq_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned NUM_SEQ = 8;

    // Output-select encoding shared with the generators
    localparam logic [CODE_W-1:0] SEQ_SQRS = 3'd0;
    localparam logic [CODE_W-1:0] SEQ_EXP3 = 3'd1;
    localparam logic [CODE_W-1:0] SEQ_TRI  = 3'd2;
    localparam logic [CODE_W-1:0] SEQ_FIB  = 3'd3;
    localparam logic [CODE_W-1:0] SEQ_PELL = 3'd4;
    localparam logic [CODE_W-1:0] SEQ_LUC  = 3'd5;
    localparam logic [CODE_W-1:0] SEQ_PAD  = 3'd6;
    localparam logic [CODE_W-1:0] SEQ_SYLV = 3'd7;

    // Term-0 recurrence state
    localparam logic [DATA_W-1:0] K_INIT     = 8'd0;
    localparam logic [DATA_W-1:0] SQ_INIT    = 8'd0;
    localparam logic [DATA_W-1:0] E3_INIT    = 8'd1;
    localparam logic [DATA_W-1:0] TRI_INIT   = 8'd0;
    localparam logic [DATA_W-1:0] FIB_A_INIT = 8'd1;
    localparam logic [DATA_W-1:0] FIB_B_INIT = 8'd1;
    localparam logic [DATA_W-1:0] PEL_A_INIT = 8'd0;
    localparam logic [DATA_W-1:0] PEL_B_INIT = 8'd1;
    localparam logic [DATA_W-1:0] LUC_A_INIT = 8'd2;
    localparam logic [DATA_W-1:0] LUC_B_INIT = 8'd1;
    localparam logic [DATA_W-1:0] PAD_A_INIT = 8'd1;
    localparam logic [DATA_W-1:0] PAD_B_INIT = 8'd1;
    localparam logic [DATA_W-1:0] PAD_C_INIT = 8'd1;
    localparam logic [DATA_W-1:0] SYL_INIT   = 8'd2;

    localparam logic [NUM_SEQ-1:0] CAND_INIT = 8'hFF;

    // Code of the lowest set bit; 0 for an empty mask
    function automatic logic [CODE_W-1:0] lowest_set(input logic [NUM_SEQ-1:0] mask);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = NUM_SEQ - 1; i >= 0; i--) begin
            if (mask[i]) code = CODE_W'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/seq_expect_bank.sv
// Expected-term models for all eight sequences, stepped once per advance.
module seq_expect_bank
    import seq_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            advance,
    output logic [NUM_SEQ-1:0][DATA_W-1:0]  exp
);

    logic [DATA_W-1:0] k_q, k_d, sq_q, sq_d, e3_q, e3_d, tri_q, tri_d;
    logic [DATA_W-1:0] fib_a_q, fib_a_d, fib_b_q, fib_b_d;
    logic [DATA_W-1:0] pel_a_q, pel_a_d, pel_b_q, pel_b_d;
    logic [DATA_W-1:0] luc_a_q, luc_a_d, luc_b_q, luc_b_d;
    logic [DATA_W-1:0] pad_a_q, pad_a_d, pad_b_q, pad_b_d, pad_c_q, pad_c_d;
    logic [DATA_W-1:0] syl_q, syl_d;
    logic [2*DATA_W-1:0] syl_prod;

    // Next-state of every recurrence; wrapping 8-bit arithmetic throughout
    always_comb begin
        k_d = k_q;   sq_d = sq_q;   e3_d = e3_q;   tri_d = tri_q;
        fib_a_d = fib_a_q; fib_b_d = fib_b_q;
        pel_a_d = pel_a_q; pel_b_d = pel_b_q;
        luc_a_d = luc_a_q; luc_b_d = luc_b_q;
        pad_a_d = pad_a_q; pad_b_d = pad_b_q; pad_c_d = pad_c_q;
        syl_d = syl_q;
        syl_prod = (2*DATA_W)'(syl_q) * (2*DATA_W)'(syl_q - 8'd1);
        if (clear) begin
            k_d = K_INIT;  sq_d = SQ_INIT;  e3_d = E3_INIT;  tri_d = TRI_INIT;
            fib_a_d = FIB_A_INIT; fib_b_d = FIB_B_INIT;
            pel_a_d = PEL_A_INIT; pel_b_d = PEL_B_INIT;
            luc_a_d = LUC_A_INIT; luc_b_d = LUC_B_INIT;
            pad_a_d = PAD_A_INIT; pad_b_d = PAD_B_INIT; pad_c_d = PAD_C_INIT;
            syl_d = SYL_INIT;
        end else if (advance) begin
            k_d     = k_q + 8'd1;
            sq_d    = sq_q + {k_q[DATA_W-2:0], 1'b0} + 8'd1;
            e3_d    = e3_q + {e3_q[DATA_W-2:0], 1'b0};
            tri_d   = tri_q + k_q + 8'd1;
            fib_a_d = fib_b_q;
            fib_b_d = fib_a_q + fib_b_q;
            pel_a_d = pel_b_q;
            pel_b_d = {pel_b_q[DATA_W-2:0], 1'b0} + pel_a_q;
            luc_a_d = luc_b_q;
            luc_b_d = luc_a_q + luc_b_q;
            pad_a_d = pad_b_q;
            pad_b_d = pad_c_q;
            pad_c_d = pad_a_q + pad_b_q;
            syl_d   = syl_prod[DATA_W-1:0] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q <= K_INIT;  sq_q <= SQ_INIT;  e3_q <= E3_INIT;  tri_q <= TRI_INIT;
            fib_a_q <= FIB_A_INIT; fib_b_q <= FIB_B_INIT;
            pel_a_q <= PEL_A_INIT; pel_b_q <= PEL_B_INIT;
            luc_a_q <= LUC_A_INIT; luc_b_q <= LUC_B_INIT;
            pad_a_q <= PAD_A_INIT; pad_b_q <= PAD_B_INIT; pad_c_q <= PAD_C_INIT;
            syl_q <= SYL_INIT;
        end else begin
            k_q <= k_d;  sq_q <= sq_d;  e3_q <= e3_d;  tri_q <= tri_d;
            fib_a_q <= fib_a_d; fib_b_q <= fib_b_d;
            pel_a_q <= pel_a_d; pel_b_q <= pel_b_d;
            luc_a_q <= luc_a_d; luc_b_q <= luc_b_d;
            pad_a_q <= pad_a_d; pad_b_q <= pad_b_d; pad_c_q <= pad_c_d;
            syl_q <= syl_d;
        end
    end

    always_comb begin
        exp           = '0;
        exp[SEQ_SQRS] = sq_q;
        exp[SEQ_EXP3] = e3_q;
        exp[SEQ_TRI]  = tri_q;
        exp[SEQ_FIB]  = fib_a_q;
        exp[SEQ_PELL] = pel_a_q;
        exp[SEQ_LUC]  = luc_a_q;
        exp[SEQ_PAD]  = pad_a_q;
        exp[SEQ_SYLV] = syl_q;
    end

endmodule

// File: rtl/seq_stream_identifier.sv
// Identifies which generated sequence (mod 256) an incoming byte stream carries
// by eliminating candidates whose expected term disagrees with each sample.
module seq_stream_identifier
    import seq_pkg::*;
#(
    parameter int unsigned MIN_LOCK = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic [NUM_SEQ-1:0] cand,
    output logic               locked,
    output logic [CODE_W-1:0]  match_code,
    output logic               mismatch,
    output logic [DATA_W-1:0]  samples
);

    localparam logic [DATA_W-1:0] MIN_LOCK_W = DATA_W'(MIN_LOCK);
    localparam logic [DATA_W-1:0] SAMPLES_MAX = '1;

    logic [NUM_SEQ-1:0][DATA_W-1:0] exp_terms;
    logic                           advance;

    logic [NUM_SEQ-1:0] cand_q, cand_d;
    logic [DATA_W-1:0]  samples_q, samples_d;
    logic [CODE_W-1:0]  match_code_q, match_code_d;
    logic               locked_q, locked_d;
    logic               mismatch_q, mismatch_d;
    logic               one_hot;

    // A sample presented together with clear is discarded
    assign advance = in_valid & ~clear;

    seq_expect_bank u_bank (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .advance (advance),
        .exp     (exp_terms)
    );

    always_comb begin
        cand_d    = cand_q;
        samples_d = samples_q;
        if (clear) begin
            cand_d    = CAND_INIT;
            samples_d = '0;
        end else if (in_valid) begin
            for (int i = 0; i < NUM_SEQ; i++) begin
                if (in_data != exp_terms[i]) cand_d[i] = 1'b0;
            end
            if (samples_q != SAMPLES_MAX) samples_d = samples_q + 8'd1;
        end
        one_hot      = (cand_d != '0) && ((cand_d & (cand_d - 8'd1)) == '0);
        locked_d     = one_hot && (samples_d >= MIN_LOCK_W);
        mismatch_d   = (cand_d == '0);
        match_code_d = lowest_set(cand_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q       <= CAND_INIT;
            samples_q    <= '0;
            match_code_q <= '0;
            locked_q     <= 1'b0;
            mismatch_q   <= 1'b0;
        end else begin
            cand_q       <= cand_d;
            samples_q    <= samples_d;
            match_code_q <= match_code_d;
            locked_q     <= locked_d;
            mismatch_q   <= mismatch_d;
        end
    end

    assign cand       = cand_q;
    assign samples    = samples_q;
    assign match_code = match_code_q;
    assign locked     = locked_q;
    assign mismatch   = mismatch_q;

endmodule

// File: tb/tb_seq_stream_identifier.sv
// Scoreboard bench for seq_stream_identifier: two instances (MIN_LOCK 3 and 5)
// share one stimulus stream; expectations come from a direct term model.
module tb_seq_stream_identifier;

    logic       clk = 1'b0;
    logic       reset, clear, in_valid;
    logic [7:0] in_data;

    logic [7:0] cand_a, samples_a, cand_b, samples_b;
    logic [2:0] code_a, code_b;
    logic       locked_a, mismatch_a, locked_b, mismatch_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] cand;
        logic [7:0] samp;
        logic [2:0] code;
        logic       mm;
        logic       lock_a;
        logic       lock_b;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [7:0] m_cand;
    int         m_n;

    always #5 clk = ~clk;

    seq_stream_identifier #(.MIN_LOCK(3)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .cand(cand_a), .locked(locked_a), .match_code(code_a), .mismatch(mismatch_a),
        .samples(samples_a)
    );

    seq_stream_identifier #(.MIN_LOCK(5)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .cand(cand_b), .locked(locked_b), .match_code(code_b), .mismatch(mismatch_b),
        .samples(samples_b)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Term n of sequence code, computed straight from its definition mod 256
    function automatic logic [7:0] term(input int code, input int n);
        int a, b, c, t;
        case (code)
            0: return 8'((n * n) % 256);
            1: begin a = 1; for (int i = 0; i < n; i++) a = (a * 3) % 256; return 8'(a); end
            2: return 8'(((n * (n + 1)) / 2) % 256);
            3, 5: begin
                a = (code == 3) ? 1 : 2; b = 1;
                for (int i = 0; i < n; i++) begin t = (a + b) % 256; a = b; b = t; end
                return 8'(a);
            end
            4: begin
                a = 0; b = 1;
                for (int i = 0; i < n; i++) begin t = (2 * b + a) % 256; a = b; b = t; end
                return 8'(a);
            end
            6: begin
                a = 1; b = 1; c = 1;
                for (int i = 0; i < n; i++) begin t = (a + b) % 256; a = b; b = c; c = t; end
                return 8'(a);
            end
            default: begin
                a = 2;
                for (int i = 0; i < n; i++) a = (a * (a - 1) + 1) % 256;
                return 8'(a);
            end
        endcase
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        int   sat;
        sat      = (m_n > 255) ? 255 : m_n;
        e.cand   = m_cand;
        e.samp   = 8'(sat);
        e.mm     = (m_cand == 8'h00);
        e.code   = 3'd0;
        for (int i = 7; i >= 0; i--) if (m_cand[i]) e.code = 3'(i);
        e.lock_a = ($countones(m_cand) == 1) && (sat >= 3);
        e.lock_b = ($countones(m_cand) == 1) && (sat >= 5);
        return e;
    endfunction

    // Drive one cycle, push the expected result, then pop and compare after the edge
    task automatic step(input logic rst, input logic clr, input logic vld, input logic [7:0] d);
        exp_t e;
        reset = rst; clear = clr; in_valid = vld; in_data = d;
        if (rst || clr) begin
            m_cand = 8'hFF; m_n = 0;
        end else if (vld) begin
            for (int i = 0; i < 8; i++) if (d != term(i, m_n)) m_cand[i] = 1'b0;
            m_n++;
        end
        sb_q.push_back(model_outputs());
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check_eq("cand_a", cand_a, e.cand);
            check_eq("samples_a", samples_a, e.samp);
            check_eq("match_code_a", code_a, e.code);
            check_eq("mismatch_a", mismatch_a, e.mm);
            check_eq("locked_a", locked_a, e.lock_a);
            check_eq("cand_b", cand_b, e.cand);
            check_eq("locked_b", locked_b, e.lock_b);
        end
    endtask

    task automatic feed(input int code, input int count);
        for (int n = 0; n < count; n++) step(1'b0, 1'b0, 1'b1, term(code, n));
    endtask

    initial begin
        logic [7:0] p;
        m_cand = 8'hFF; m_n = 0;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h55);
        check_eq("reset_cand", cand_a, 8'hFF);
        check_eq("reset_samples", samples_a, 0);

        // Fibonacci 1,1,2,3,5,8 with an idle cycle in the middle
        feed(3, 3);
        check_eq("fib3_cand", cand_a, 8'h08);
        check_eq("fib3_locked", locked_a, 1);
        check_eq("fib3_code", code_a, 3);
        step(1'b0, 1'b0, 1'b0, 8'hAA);
        step(1'b0, 1'b0, 1'b1, 8'd3);
        step(1'b0, 1'b0, 1'b1, 8'd5);
        step(1'b0, 1'b0, 1'b1, 8'd8);
        check_eq("fib6_code", code_a, 3);

        // Padovan vs Fibonacci diverge on the third sample
        step(1'b0, 1'b1, 1'b0, 8'h00);
        feed(6, 2);
        check_eq("padfib2_cand", cand_a, 8'h48);
        step(1'b0, 1'b0, 1'b1, 8'd1);
        check_eq("pad3_cand", cand_a, 8'h40);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        feed(3, 2);
        step(1'b0, 1'b0, 1'b1, 8'd2);
        check_eq("fib3b_cand", cand_a, 8'h08);

        // Sylvester through the wrap values, then a bad sample
        step(1'b0, 1'b1, 1'b0, 8'h00);
        feed(7, 7);
        check_eq("syl_code", code_a, 7);
        check_eq("syl_locked", locked_a, 1);
        step(1'b0, 1'b0, 1'b1, 8'd24);
        check_eq("syl_bad_cand", cand_a, 8'h00);
        check_eq("syl_bad_mm", mismatch_a, 1);
        check_eq("syl_bad_locked", locked_a, 0);
        step(1'b0, 1'b0, 1'b1, 8'd1);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("mm_sticky", mismatch_a, 1);

        // Powers of 3, 300 back-to-back samples
        step(1'b0, 1'b1, 1'b0, 8'h00);
        p = 8'd1;
        for (int n = 0; n < 300; n++) begin
            step(1'b0, 1'b0, 1'b1, p);
            p = 8'(p * 8'd3);
        end
        check_eq("exp3_samples_sat", samples_a, 255);
        check_eq("exp3_locked", locked_a, 1);
        check_eq("exp3_mm", mismatch_a, 0);

        // Sample presented with clear is discarded
        step(1'b0, 1'b1, 1'b1, 8'd99);
        feed(0, 3);
        check_eq("sq_cand", cand_a, 8'h01);
        check_eq("sq_code", code_a, 0);

        // Reset mid-stream, then Lucas against MIN_LOCK 5
        feed(5, 2);
        step(1'b1, 1'b0, 1'b1, 8'd2);
        feed(5, 2);
        check_eq("luc2_cand", cand_b, 8'h20);
        check_eq("luc2_locked_b", locked_b, 0);
        step(1'b0, 1'b0, 1'b1, 8'd3);
        step(1'b0, 1'b0, 1'b1, 8'd4);
        check_eq("luc4_locked_b", locked_b, 0);
        check_eq("luc4_locked_a", locked_a, 1);
        step(1'b0, 1'b0, 1'b1, 8'd7);
        check_eq("luc5_locked_b", locked_b, 1);

        // Random idle/valid mix on Pell
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int n = 0; n < 20; ) begin
            if ($urandom_range(0, 2) != 0) begin
                step(1'b0, 1'b0, 1'b1, term(4, n));
                n++;
            end else begin
                step(1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
            end
        end
        check_eq("pell_code", code_a, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
